fifoc2cs_parser: RTL and testbench

- Command-path reader between FIFO C and the control system.
- On each fs_fifoc2cs request it drains one received UDP command frame from FIFO C.
- It validates the header and checksum, then updates the nine cmd_* registers that the control system consumes.
- It returns fd_fifoc2cs to complete the fs/fd handshake.

---
 rtl/fifoc2cs_parser.sv | 138 +++++++++++++
 tb/tb_fifoc2cs_parser.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/fifoc2cs_parser.sv
// Command-path reader: drains one UDP command frame from FIFO C per fs request,
// validates header and checksum, and atomically updates the nine cmd_* registers.
module fifoc2cs_parser #(
    parameter logic [7:0] HEAD0   = 8'h55,
    parameter logic [7:0] HEAD1   = 8'hAA,
    parameter int         FRM_LEN = 12
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        fs,
    output logic        fd,
    input  logic [11:0] rx_len,
    input  logic [7:0]  fifoc_rxd,
    input  logic        fifoc_empty,
    output logic        fifoc_rxen,
    output logic [7:0]  cmd_kdev,
    output logic [7:0]  cmd_smpr,
    output logic [7:0]  cmd_filt,
    output logic [7:0]  cmd_mix0,
    output logic [7:0]  cmd_mix1,
    output logic [7:0]  cmd_reg4,
    output logic [7:0]  cmd_reg5,
    output logic [7:0]  cmd_reg6,
    output logic [7:0]  cmd_reg7,
    output logic        cmd_vld,
    output logic        err
);

    localparam logic [11:0] FRM_LEN_W = FRM_LEN[11:0];

    typedef enum logic [2:0] {IDLE, READ, FLUSH, CHECK, DONE} state_t;

    state_t      state;
    logic [11:0] rissue;
    logic [11:0] ic;
    logic [11:0] dc;
    logic [7:0]  acc;
    logic        bad;
    logic        dv;
    logic [7:0]  shadow [0:8];
    logic [11:0] ic_next;
    logic [3:0]  sidx;

    // Read enable stays combinational so an empty FIFO stops popping in the same cycle.
    assign fifoc_rxen = (state == READ) && !fifoc_empty && (ic < rissue);
    assign ic_next    = ic + {11'd0, fifoc_rxen};
    assign sidx       = dc[3:0] - 4'd2;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            rissue   <= '0;
            ic       <= '0;
            dc       <= '0;
            acc      <= '0;
            bad      <= 1'b0;
            dv       <= 1'b0;
            fd       <= 1'b0;
            cmd_vld  <= 1'b0;
            err      <= 1'b0;
            cmd_kdev <= '0;
            cmd_smpr <= '0;
            cmd_filt <= '0;
            cmd_mix0 <= '0;
            cmd_mix1 <= '0;
            cmd_reg4 <= '0;
            cmd_reg5 <= '0;
            cmd_reg6 <= '0;
            cmd_reg7 <= '0;
            for (int i = 0; i < 9; i++) shadow[i] <= '0;
        end else begin
            cmd_vld <= 1'b0;
            err     <= 1'b0;
            dv      <= fifoc_rxen;

            // Bytes past the checksum are consumed but ignored to keep the FIFO frame-aligned.
            if (dv) begin
                if (dc == 12'd0) begin
                    if (fifoc_rxd != HEAD0) bad <= 1'b1;
                end else if (dc == 12'd1) begin
                    if (fifoc_rxd != HEAD1) bad <= 1'b1;
                end else if (dc <= 12'd10) begin
                    shadow[sidx] <= fifoc_rxd;
                    acc          <= acc + fifoc_rxd;
                end else if (dc == 12'd11) begin
                    if (fifoc_rxd != acc) bad <= 1'b1;
                end
                if (dc != 12'hFFF) dc <= dc + 12'd1;
            end

            case (state)
                IDLE: begin
                    fd <= 1'b0;
                    if (fs) begin
                        rissue <= rx_len;
                        ic     <= '0;
                        dc     <= '0;
                        acc    <= '0;
                        bad    <= 1'b0;
                        state  <= (rx_len == 12'd0) ? CHECK : READ;
                    end
                end
                READ: begin
                    ic <= ic_next;
                    if (ic_next == rissue) state <= FLUSH;
                end
                FLUSH: state <= CHECK;
                CHECK: begin
                    if (!bad && (dc >= FRM_LEN_W)) begin
                        cmd_kdev <= shadow[0];
                        cmd_smpr <= shadow[1];
                        cmd_filt <= shadow[2];
                        cmd_mix0 <= shadow[3];
                        cmd_mix1 <= shadow[4];
                        cmd_reg4 <= shadow[5];
                        cmd_reg5 <= shadow[6];
                        cmd_reg6 <= shadow[7];
                        cmd_reg7 <= shadow[8];
                        cmd_vld  <= 1'b1;
                    end else begin
                        err <= 1'b1;
                    end
                    state <= DONE;
                end
                DONE: begin
                    if (fs) begin
                        fd <= 1'b1;
                    end else begin
                        fd    <= 1'b0;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fifoc2cs_parser.sv
// Self-checking bench for fifoc2cs_parser: table of command frames against a FIFO C model,
// plus a hand-written mid-frame reset sequence.
module tb_fifoc2cs_parser;

    logic        clk = 1'b0;
    logic        rst;
    logic        fs;
    logic        fd;
    logic [11:0] rx_len;
    logic [7:0]  fifoc_rxd = 8'h00;
    logic        fifoc_empty;
    logic        fifoc_rxen;
    logic [7:0]  cmd_kdev, cmd_smpr, cmd_filt, cmd_mix0, cmd_mix1;
    logic [7:0]  cmd_reg4, cmd_reg5, cmd_reg6, cmd_reg7;
    logic        cmd_vld;
    logic        err;

    logic [7:0]  mem [0:1023];
    int          wrPtr = 0;
    int          rdPtr = 0;
    logic        stall = 1'b0;
    int          vldCount = 0;
    int          errCount = 0;
    int          stallViol = 0;
    int          checks = 0;
    int          errors = 0;

    typedef struct {
        logic [11:0]  len;
        int           nbytes;
        logic [127:0] data;
        bit           expVld;
        logic [71:0]  expCmd;
        int           expCycles;
        int           stallAt;
        int           stallLen;
    } vec_t;

    vec_t vecs [0:8];

    fifoc2cs_parser dut (
        .clk        (clk),
        .rst        (rst),
        .fs         (fs),
        .fd         (fd),
        .rx_len     (rx_len),
        .fifoc_rxd  (fifoc_rxd),
        .fifoc_empty(fifoc_empty),
        .fifoc_rxen (fifoc_rxen),
        .cmd_kdev   (cmd_kdev),
        .cmd_smpr   (cmd_smpr),
        .cmd_filt   (cmd_filt),
        .cmd_mix0   (cmd_mix0),
        .cmd_mix1   (cmd_mix1),
        .cmd_reg4   (cmd_reg4),
        .cmd_reg5   (cmd_reg5),
        .cmd_reg6   (cmd_reg6),
        .cmd_reg7   (cmd_reg7),
        .cmd_vld    (cmd_vld),
        .err        (err)
    );

    always #5 clk = ~clk;

    // FIFO C model: data appears one cycle after the read enable; flushed along with the DUT reset.
    assign fifoc_empty = stall || (rdPtr == wrPtr);

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            rdPtr <= wrPtr;
        end else if (fifoc_rxen) begin
            fifoc_rxd <= mem[rdPtr];
            rdPtr     <= rdPtr + 1;
        end
    end

    always @(posedge clk) begin
        if (cmd_vld) vldCount <= vldCount + 1;
        if (err) errCount <= errCount + 1;
        if (stall && fifoc_rxen) stallViol <= stallViol + 1;
    end

    function automatic logic [71:0] cmdBus();
        return {cmd_kdev, cmd_smpr, cmd_filt, cmd_mix0, cmd_mix1,
                cmd_reg4, cmd_reg5, cmd_reg6, cmd_reg7};
    endfunction

    function automatic vec_t mk(input logic [11:0] len, input int nbytes, input logic [127:0] data,
                                input bit vld, input logic [71:0] cmd, input int cycles,
                                input int stallAt, input int stallLen);
        vec_t v;
        v.len       = len;
        v.nbytes    = nbytes;
        v.data      = data;
        v.expVld    = vld;
        v.expCmd    = cmd;
        v.expCycles = cycles;
        v.stallAt   = stallAt;
        v.stallLen  = stallLen;
        return v;
    endfunction

    task automatic check(input string name, input logic [71:0] act, input logic [71:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Loads the frame into FIFO C, raises fs and waits (bounded) for fd, counting cycles from the fs sample edge.
    task automatic applyStimulus(input vec_t v, output int fdCycle, output int vldCycle,
                                 output bit timedOut);
        logic [127:0] d;
        d = v.data;
        for (int j = 0; j < v.nbytes; j++) begin
            mem[wrPtr] = d[127 - 8*j -: 8];
            wrPtr++;
        end
        @(negedge clk);
        rx_len = v.len;
        fs = 1'b1;
        @(posedge clk);
        fdCycle  = -1;
        vldCycle = -1;
        timedOut = 1'b1;
        for (int c = 1; c <= 200; c++) begin
            @(posedge clk);
            #1;
            if (v.stallLen > 0 && c == v.stallAt) stall = 1'b1;
            if (v.stallLen > 0 && c == v.stallAt + v.stallLen) stall = 1'b0;
            if (cmd_vld && vldCycle < 0) vldCycle = c;
            if (fd) begin
                fdCycle  = c;
                timedOut = 1'b0;
                break;
            end
        end
        stall = 1'b0;
    endtask

    task automatic checkOutput(input int idx);
        vec_t v;
        int   fdCycle, vldCycle, rd0, vld0, err0;
        bit   timedOut;
        v    = vecs[idx];
        rd0  = rdPtr;
        vld0 = vldCount;
        err0 = errCount;
        applyStimulus(v, fdCycle, vldCycle, timedOut);
        check($sformatf("v%0d fd_timeout", idx), {71'd0, timedOut}, 72'd0);
        check($sformatf("v%0d fd_latency", idx), 72'(fdCycle), 72'(v.expCycles));
        check($sformatf("v%0d rxen_count", idx), 72'(rdPtr - rd0), 72'(v.len));
        check($sformatf("v%0d fifo_drained", idx), {71'd0, rdPtr == wrPtr}, 72'd1);
        check($sformatf("v%0d cmd_regs", idx), cmdBus(), v.expCmd);
        check($sformatf("v%0d cmd_vld_pulses", idx), 72'(vldCount - vld0), 72'(v.expVld ? 1 : 0));
        check($sformatf("v%0d err_pulses", idx), 72'(errCount - err0), 72'(v.expVld ? 0 : 1));
        if (v.expVld)
            check($sformatf("v%0d vld_before_fd", idx), 72'(vldCycle), 72'(fdCycle - 1));
        @(negedge clk);
        fs = 1'b0;
        @(posedge clk);
        #1;
        check($sformatf("v%0d fd_drop", idx), {71'd0, fd}, 72'd0);
        @(posedge clk);
        #1;
        check($sformatf("v%0d idle_no_rxen", idx), {70'd0, fd, fifoc_rxen}, 72'd0);
    endtask

    initial begin
        int rd0;
        vecs[0] = mk(12'd12, 12, 128'h55AA0102030405060708092D_00000000, 1'b1,
                     72'h010203040506070809, 15, 0, 0);
        vecs[1] = mk(12'd12, 12, 128'h55AA0102030405060708092E_00000000, 1'b0,
                     72'h010203040506070809, 15, 0, 0);
        vecs[2] = mk(12'd12, 12, 128'h54AA0102030405060708092D_00000000, 1'b0,
                     72'h010203040506070809, 15, 0, 0);
        vecs[3] = mk(12'd12, 12, 128'h55AA101112131415161718B4_00000000, 1'b1,
                     72'h101112131415161718, 15, 0, 0);
        vecs[4] = mk(12'd16, 16, 128'h55AA2122232425262728294D_55AA00FF, 1'b1,
                     72'h212223242526272829, 19, 0, 0);
        vecs[5] = mk(12'd8, 8, 128'h55AA010203040506_0000000000000000, 1'b0,
                     72'h212223242526272829, 11, 0, 0);
        vecs[6] = mk(12'd0, 0, 128'h0, 1'b0,
                     72'h212223242526272829, 2, 0, 0);
        vecs[7] = mk(12'd12, 12, 128'h55AA313233343536373839DD_00000000, 1'b1,
                     72'h313233343536373839, 20, 4, 5);
        vecs[8] = mk(12'd12, 12, 128'h55AA4142434445464748496D_00000000, 1'b1,
                     72'h414243444546474849, 15, 0, 0);

        rst    = 1'b0;
        fs     = 1'b0;
        rx_len = 12'd0;
        #2;
        check("reset_outputs", {cmd_vld, err, fd, fifoc_rxen, cmdBus()}, '0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);

        for (int i = 0; i < 8; i++) checkOutput(i);
        check("stall_no_rxen", 72'(stallViol), 72'd0);

        // Reset mid-READ after six bytes have been popped.
        rd0 = rdPtr;
        for (int j = 0; j < 12; j++) begin
            mem[wrPtr] = 8'h55 + 8'(j);
            wrPtr++;
        end
        @(negedge clk);
        rx_len = 12'd12;
        fs = 1'b1;
        @(posedge clk);
        repeat (6) @(posedge clk);
        #1;
        check("midread_bytes_popped", 72'(rdPtr - rd0), 72'd6);
        rst = 1'b0;
        #1;
        check("async_reset_outputs", {cmd_vld, err, fd, fifoc_rxen, cmdBus()}, '0);
        fs = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("post_reset_idle", {69'd0, fd, fifoc_rxen, rdPtr == wrPtr}, 72'd1);

        checkOutput(8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
